opr_sequencer: RTL and testbench

- Upstream counterpart of the operand demultiplexer: fetches opcode/operand byte pairs from instruction memory and decodes them.
- Produces the 3-bit OPR_sel and the 8-bit operand that the demux routes to the RESET/WTA/WTR/INC units.
- Handshakes with the execution side: holds each command stable until the target unit signals completion.
- Sits between instruction memory and the operand demux in the CCSS datapath.

---
 rtl/opr_sequencer.sv | 138 +++++++++++++
 tb/tb_opr_sequencer.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/opr_sequencer.sv
// Instruction sequencer: fetches opcode/operand byte pairs from instruction memory
// and issues OPR_sel/operand commands to the operand demux with a done handshake.
module opr_sequencer #(
  parameter int AW         = 8,
  parameter int START_ADDR = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic [AW-1:0] imem_addr,
  input  logic [7:0]    imem_rdata,
  output logic [2:0]    OPR_sel,
  output logic [7:0]    operand,
  output logic          issue_valid,
  input  logic          exec_done,
  output logic          busy,
  output logic          halted,
  output logic          err
);

  localparam logic [AW-1:0] START_PC = AW'(START_ADDR);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_FETCH_OP  = 3'd1;
  localparam logic [2:0] S_DEC_OP    = 3'd2;
  localparam logic [2:0] S_FETCH_OPR = 3'd3;
  localparam logic [2:0] S_LOAD_OPR  = 3'd4;
  localparam logic [2:0] S_ISSUE     = 3'd5;
  localparam logic [2:0] S_WAIT_DONE = 3'd6;
  localparam logic [2:0] S_HALT      = 3'd7;

  logic [2:0]    state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] imem_addr_q, imem_addr_d;
  logic [2:0]    cmd_sel_q, cmd_sel_d;
  logic [2:0]    opr_sel_q, opr_sel_d;
  logic [7:0]    operand_q, operand_d;
  logic          issue_valid_q, issue_valid_d;
  logic          err_q, err_d;
  logic [AW-1:0] pc_inc;

  always_comb begin
    pc_inc    = pc_q + AW'(1);
    state_d   = state_q;
    pc_d      = pc_q;
    cmd_sel_d = cmd_sel_q;
    err_d     = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          pc_d    = START_PC;
          state_d = S_FETCH_OP;
        end
      end
      S_HALT: begin
        if (start) begin
          pc_d    = START_PC;
          err_d   = 1'b0;
          state_d = S_FETCH_OP;
        end
      end
      S_FETCH_OP: state_d = S_DEC_OP;
      S_DEC_OP: begin
        pc_d = pc_inc;
        case (imem_rdata)
          8'h00: state_d = S_FETCH_OP;
          8'h01, 8'h02, 8'h03, 8'h04: begin
            cmd_sel_d = imem_rdata[2:0];
            state_d   = S_FETCH_OPR;
          end
          8'hFF: state_d = S_HALT;
          default: begin
            err_d   = 1'b1;
            state_d = S_HALT;
          end
        endcase
      end
      S_FETCH_OPR: state_d = S_LOAD_OPR;
      S_LOAD_OPR: begin
        pc_d    = pc_inc;
        state_d = S_ISSUE;
      end
      S_ISSUE, S_WAIT_DONE: state_d = exec_done ? S_FETCH_OP : S_WAIT_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // The address register follows pc into each fetch state so the read data lands in the next state.
  always_comb begin
    imem_addr_d   = imem_addr_q;
    opr_sel_d     = 3'b000;
    operand_d     = 8'h00;
    issue_valid_d = 1'b0;
    if (state_d == S_FETCH_OP || state_d == S_FETCH_OPR) begin
      imem_addr_d = pc_d;
    end
    // ISSUE is only reachable from LOAD_OPR, so the operand byte is on imem_rdata right now.
    if (state_d == S_ISSUE) begin
      opr_sel_d     = cmd_sel_q;
      operand_d     = imem_rdata;
      issue_valid_d = 1'b1;
    end else if (state_d == S_WAIT_DONE) begin
      opr_sel_d = opr_sel_q;
      operand_d = operand_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      pc_q          <= START_PC;
      imem_addr_q   <= START_PC;
      cmd_sel_q     <= 3'b000;
      opr_sel_q     <= 3'b000;
      operand_q     <= 8'h00;
      issue_valid_q <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      imem_addr_q   <= imem_addr_d;
      cmd_sel_q     <= cmd_sel_d;
      opr_sel_q     <= opr_sel_d;
      operand_q     <= operand_d;
      issue_valid_q <= issue_valid_d;
      err_q         <= err_d;
    end
  end

  assign imem_addr   = imem_addr_q;
  assign OPR_sel     = opr_sel_q;
  assign operand     = operand_q;
  assign issue_valid = issue_valid_q;
  assign err         = err_q;
  assign busy        = (state_q != S_IDLE) && (state_q != S_HALT);
  assign halted      = (state_q == S_HALT);

endmodule

// File: tb/tb_opr_sequencer.sv
// Bench for opr_sequencer: instruction-timeline reference model with per-cycle compare,
// directed scenarios with literal expectations, and randomized programs.
module tb_opr_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start0, start1, done0, done1;
  logic [7:0] addr0;
  logic [1:0] addr1;
  logic [7:0] rd0, rd1;
  logic [2:0] sel0, sel1;
  logic [7:0] opr0, opr1;
  logic       iv0, iv1, busy0, busy1, halted0, halted1, err0, err1;
  logic [7:0] mem0 [256];
  logic [7:0] mem1 [4];

  opr_sequencer dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .imem_addr(addr0), .imem_rdata(rd0),
    .OPR_sel(sel0), .operand(opr0), .issue_valid(iv0), .exec_done(done0),
    .busy(busy0), .halted(halted0), .err(err0)
  );

  opr_sequencer #(.AW(2), .START_ADDR(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .imem_addr(addr1), .imem_rdata(rd1),
    .OPR_sel(sel1), .operand(opr1), .issue_valid(iv1), .exec_done(done1),
    .busy(busy1), .halted(halted1), .err(err1)
  );

  // Synchronous-read instruction memories
  always @(posedge clk) begin
    rd0 <= mem0[addr0];
    rd1 <= mem1[addr1];
  end

  int errors = 0;
  int checks = 0;
  int edge_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  initial forever begin
    @(posedge clk);
    edge_cnt++;
  end

  // Reference model: each instruction is a timeline counted in cycles from its fetch edge.
  localparam int MI = 0, MR = 1, MH = 2;
  int m_mode [2] = '{MI, MI};
  int m_pc   [2] = '{0, 3};
  int m_cyc  [2] = '{0, 0};
  bit m_err  [2] = '{1'b0, 1'b0};

  function automatic int mmask(input int k);
    return (k == 0) ? 255 : 3;
  endfunction

  function automatic int mstart(input int k);
    return (k == 0) ? 0 : 3;
  endfunction

  function automatic int mrd(input int k, input int a);
    if (k == 0) return int'(mem0[8'(a)]);
    return int'(mem1[2'(a)]);
  endfunction

  task automatic model_step(input int k);
    int op;
    bit st, dn;
    st = (k == 0) ? start0 : start1;
    dn = (k == 0) ? done0 : done1;
    if (!rst_n) begin
      m_mode[k] = MI; m_pc[k] = mstart(k); m_cyc[k] = 0; m_err[k] = 1'b0;
      return;
    end
    case (m_mode[k])
      MI, MH: begin
        if (st) begin
          m_mode[k] = MR; m_pc[k] = mstart(k); m_cyc[k] = 0; m_err[k] = 1'b0;
        end
      end
      default: begin
        m_cyc[k]++;
        op = mrd(k, m_pc[k]);
        if (op == 0) begin
          if (m_cyc[k] == 2) begin
            m_pc[k] = (m_pc[k] + 1) & mmask(k); m_cyc[k] = 0;
          end
        end else if (op >= 1 && op <= 4) begin
          if (m_cyc[k] >= 5 && dn) begin
            m_pc[k] = (m_pc[k] + 2) & mmask(k); m_cyc[k] = 0;
          end
        end else if (m_cyc[k] == 2) begin
          m_mode[k] = MH;
          if (op != 255) m_err[k] = 1'b1;
        end
      end
    endcase
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    for (int k = 0; k < 2; k++) model_step(k);
  end

  task automatic compare(input int k);
    int op, e_sel, e_opr;
    bit cmd;
    op    = mrd(k, m_pc[k]);
    cmd   = (m_mode[k] == MR) && (op >= 1) && (op <= 4) && (m_cyc[k] >= 4);
    e_sel = cmd ? op : 0;
    e_opr = cmd ? mrd(k, (m_pc[k] + 1) & mmask(k)) : 0;
    if (k == 0) begin
      check("busy0", int'(busy0), int'(m_mode[0] == MR));
      check("halted0", int'(halted0), int'(m_mode[0] == MH));
      check("err0", int'(err0), int'(m_err[0]));
      check("issue_valid0", int'(iv0), int'(cmd && m_cyc[0] == 4));
      check("opr_sel0", int'(sel0), e_sel);
      check("operand0", int'(opr0), e_opr);
    end else begin
      check("busy1", int'(busy1), int'(m_mode[1] == MR));
      check("halted1", int'(halted1), int'(m_mode[1] == MH));
      check("err1", int'(err1), int'(m_err[1]));
      check("issue_valid1", int'(iv1), int'(cmd && m_cyc[1] == 4));
      check("opr_sel1", int'(sel1), e_sel);
      check("operand1", int'(opr1), e_opr);
    end
  endtask

  // Per-cycle compare plus issue bookkeeping for the directed expectations
  int n_iss0 = 0, n_iss1 = 0;
  int last_edge0 = 0, last_sel0 = 0, last_opr0 = 0, last_sel1 = 0, last_opr1 = 0;
  int q_sel0 [$];
  int q_opr0 [$];

  initial forever begin
    @(negedge clk);
    for (int k = 0; k < 2; k++) compare(k);
    if (iv0) begin
      n_iss0++; last_edge0 = edge_cnt; last_sel0 = int'(sel0); last_opr0 = int'(opr0);
      q_sel0.push_back(int'(sel0)); q_opr0.push_back(int'(opr0));
    end
    if (iv1) begin
      n_iss1++; last_sel1 = int'(sel1); last_opr1 = int'(opr1);
    end
  end

  // exec_done driver for dut0: 0 = tied level, 1 = fixed delay after issue, 2 = random
  int dmode0 = 0, dly0 = 0, dcnt0 = 0;
  bit tie0 = 1'b1;
  initial forever begin
    @(negedge clk);
    case (dmode0)
      1: begin
        if (iv0) dcnt0 = dly0;
        else if (dcnt0 > 0) dcnt0--;
        done0 = (dcnt0 == 0);
      end
      2: done0 = ($urandom_range(0, 2) == 0);
      default: done0 = tie0;
    endcase
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start(input int k);
    if (k == 0) start0 = 1'b1; else start1 = 1'b1;
    tick();
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic wait_halt(input int k, input int maxc);
    int c;
    c = 0;
    while (((k == 0) ? halted0 : halted1) == 1'b0 && c < maxc) begin
      tick();
      c++;
    end
    check("halt_reached", int'((k == 0) ? halted0 : halted1), 1);
  endtask

  task automatic clear_mem0();
    for (int i = 0; i < 256; i++) mem0[i] = 8'h00;
  endtask

  int t0;

  initial begin
    rst_n  = 1'b0;
    start0 = 1'b0;
    start1 = 1'b0;
    done0  = 1'b1;
    done1  = 1'b1;
    clear_mem0();
    for (int i = 0; i < 4; i++) mem1[i] = 8'h00;
    tick(3);
    check("rst_sel", int'(sel0), 0);
    check("rst_operand", int'(opr0), 0);
    check("rst_issue", int'(iv0), 0);
    check("rst_busy", int'(busy0), 0);
    check("rst_halted", int'(halted0), 0);
    check("rst_err", int'(err0), 0);
    check("rst_addr0", int'(addr0), 0);
    check("rst_addr1", int'(addr1), 3);
    rst_n = 1'b1;
    tick();

    // Single WTR then END, exec_done tied high
    mem0[0] = 8'h03; mem0[1] = 8'h5A; mem0[2] = 8'hFF;
    n_iss0 = 0;
    t0 = edge_cnt;
    pulse_start(0);
    wait_halt(0, 50);
    check("t1_issues", n_iss0, 1);
    check("t1_sel", last_sel0, 3);
    check("t1_operand", last_opr0, 8'h5A);
    check("t1_issue_latency", last_edge0 - t0, 5);
    check("t1_busy", int'(busy0), 0);
    check("t1_err", int'(err0), 0);
    check("t1_sel_idle", int'(sel0), 0);

    // Four commands, each completed 3 cycles after issue
    clear_mem0();
    mem0[0] = 8'h01; mem0[1] = 8'h11; mem0[2] = 8'h02; mem0[3] = 8'h22;
    mem0[4] = 8'h03; mem0[5] = 8'h33; mem0[6] = 8'h04; mem0[7] = 8'h44; mem0[8] = 8'hFF;
    dmode0 = 1; dly0 = 3;
    n_iss0 = 0; q_sel0.delete(); q_opr0.delete();
    pulse_start(0);
    wait_halt(0, 200);
    check("t2_issues", n_iss0, 4);
    for (int i = 0; i < 4; i++) begin
      check("t2_sel", (i < q_sel0.size()) ? q_sel0[i] : -1, i + 1);
      check("t2_operand", (i < q_opr0.size()) ? q_opr0[i] : -1, 8'h11 * (i + 1));
    end

    // Two NOPs before INC: issue shifts by 4 cycles
    clear_mem0();
    mem0[0] = 8'h00; mem0[1] = 8'h00; mem0[2] = 8'h04; mem0[3] = 8'h7F; mem0[4] = 8'hFF;
    dmode0 = 0; tie0 = 1'b1;
    n_iss0 = 0;
    t0 = edge_cnt;
    pulse_start(0);
    wait_halt(0, 60);
    check("t3_issues", n_iss0, 1);
    check("t3_issue_latency", last_edge0 - t0, 9);
    check("t3_sel", last_sel0, 4);
    check("t3_operand", last_opr0, 8'h7F);

    // Illegal opcode, then restart into END
    clear_mem0();
    mem0[0] = 8'h09;
    n_iss0 = 0;
    pulse_start(0);
    wait_halt(0, 20);
    check("t4_err", int'(err0), 1);
    check("t4_issues", n_iss0, 0);
    mem0[0] = 8'hFF;
    pulse_start(0);
    check("t4_err_cleared", int'(err0), 0);
    check("t4_busy", int'(busy0), 1);
    wait_halt(0, 20);
    check("t4_err_final", int'(err0), 0);

    // Reset while waiting on a WTA
    clear_mem0();
    mem0[0] = 8'h02; mem0[1] = 8'h80; mem0[2] = 8'hFF;
    tie0 = 1'b0;
    pulse_start(0);
    tick(8);
    check("t5_wait_sel", int'(sel0), 2);
    check("t5_wait_operand", int'(opr0), 8'h80);
    pulse_start(0);
    check("t5_start_ignored", int'(sel0), 2);
    #2 rst_n = 1'b0;
    #1;
    check("t5_async_sel", int'(sel0), 0);
    check("t5_async_operand", int'(opr0), 0);
    check("t5_async_busy", int'(busy0), 0);
    check("t5_async_halted", int'(halted0), 0);
    check("t5_async_addr", int'(addr0), 0);
    tick(2);
    rst_n = 1'b1;
    tick();
    check("t5_idle_busy", int'(busy0), 0);
    check("t5_idle_halted", int'(halted0), 0);
    tie0 = 1'b1;
    n_iss0 = 0;
    pulse_start(0);
    tick(2);
    pulse_start(0);
    wait_halt(0, 40);
    check("t5_issues", n_iss0, 1);
    check("t5_operand", last_opr0, 8'h80);

    // AW=2 instance: operand fetched across the pc wrap
    mem1[3] = 8'h02; mem1[0] = 8'hC3; mem1[1] = 8'hFF; mem1[2] = 8'h00;
    done1 = 1'b1;
    n_iss1 = 0;
    pulse_start(1);
    wait_halt(1, 40);
    check("t6_issues", n_iss1, 1);
    check("t6_sel", last_sel1, 2);
    check("t6_operand", last_opr1, 8'hC3);
    check("t6_err", int'(err1), 0);

    // Randomized programs with random completion behaviour
    for (int r = 0; r < 30; r++) begin
      int a, ncmd, ninstr, t;
      bit ill;
      clear_mem0();
      a = 0; ncmd = 0; ill = 1'b0;
      ninstr = int'($urandom_range(1, 12));
      for (int i = 0; i < ninstr && !ill; i++) begin
        t = int'($urandom_range(0, 19));
        if (t < 4) begin
          mem0[a] = 8'h00; a++;
        end else if (t < 19) begin
          mem0[a] = 8'($urandom_range(1, 4));
          mem0[a + 1] = 8'($urandom_range(0, 255));
          a += 2; ncmd++;
        end else begin
          mem0[a] = 8'($urandom_range(5, 254)); a++; ill = 1'b1;
        end
      end
      if (!ill) mem0[a] = 8'hFF;
      dmode0 = int'($urandom_range(0, 2));
      dly0 = int'($urandom_range(0, 4));
      tie0 = 1'b1;
      n_iss0 = 0;
      pulse_start(0);
      wait_halt(0, 400);
      check("rand_issues", n_iss0, ncmd);
      check("rand_err", int'(err0), int'(ill));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
